// File: rtl/i2c_arb_pkg.sv
// Shared state encoding, bus-condition patterns and default timing limits
// for the I2C multi-master arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Bus condition patterns over {scl_prev, scl, sda_prev, sda}.
  localparam logic [3:0] COND_START = 4'b1110;
  localparam logic [3:0] COND_STOP  = 4'b1101;

  localparam int DEF_IDLE_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Watches the shared wire for START/STOP, tracks bus-busy and counts
// idle cycles so the arbiter knows when the bus has been free long enough.
module i2c_bus_monitor
  import i2c_arb_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  input  logic clr_i,
  output logic start_o,
  output logic stop_o,
  output logic scl_edge_o,
  output logic busy_o,
  output logic bus_free_o
);

  localparam int FW = $clog2(IDLE_CYCLES + 1);

  logic          scl_prev_q;
  logic          sda_prev_q;
  logic          busy_q;
  logic [FW-1:0] free_q;
  logic [3:0]    cond;

  assign cond       = {scl_prev_q, scl_i, sda_prev_q, sda_i};
  assign start_o    = (cond == COND_START);
  assign stop_o     = (cond == COND_STOP);
  assign scl_edge_o = scl_prev_q ^ scl_i;
  assign busy_o     = busy_q;
  assign bus_free_o = (free_q == FW'(IDLE_CYCLES));

  // A STOP in the same cycle as a START leaves the bus free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      busy_q     <= 1'b0;
      free_q     <= '0;
    end else begin
      scl_prev_q <= scl_i;
      sda_prev_q <= sda_i;
      if (stop_o) begin
        busy_q <= 1'b0;
      end else if (start_o) begin
        busy_q <= 1'b1;
      end
      if (start_o || stop_o || !scl_i || !sda_i || clr_i) begin
        free_q <= '0;
      end else if (!busy_q && free_q != FW'(IDLE_CYCLES)) begin
        free_q <= free_q + FW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_mst_arbiter.sv
// Round-robin arbiter sharing one I2C bus between NUM_REQ master engines.
// Define I2C_ARB_LOCK_EN to add i_lock, which keeps the grant across STOP.
module i2c_mst_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int IDLE_CYCLES    = DEF_IDLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_scl_req,
  input  logic [NUM_REQ-1:0] i_sda_req,
`ifdef I2C_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] i_lock,
`endif
  input  logic               i_scl,
  input  logic               i_sda,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_scl,
  output logic               o_sda,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e         state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      win_q;
  logic [TW-1:0]      tcnt_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               scl_q;
  logic               sda_q;
  logic               timeout_q;

  logic [IW-1:0] pick;
  logic          start, stop, scl_edge, busy, bus_free, issue, win_lock;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NUM_REQ - 1)) ? '0 : v + IW'(1);
  endfunction

  // First requester at or after ptr, wrapping at NUM_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] idx;
    logic          found;
    rr_pick = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = wrap_inc(idx);
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign pick  = rr_pick(i_req, ptr_q);
  assign issue = (state_q == ST_IDLE) && (|i_req) && bus_free;

`ifdef I2C_ARB_LOCK_EN
  assign win_lock = i_lock[win_q];
`else
  assign win_lock = 1'b0;
`endif

  i2c_bus_monitor #(
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_mon (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .scl_i     (i_scl),
    .sda_i     (i_sda),
    .clr_i     (issue),
    .start_o   (start),
    .stop_o    (stop),
    .scl_edge_o(scl_edge),
    .busy_o    (busy),
    .bus_free_o(bus_free)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      tcnt_q    <= '0;
      gnt_q     <= '0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          scl_q <= 1'b1;
          sda_q <= 1'b1;
          if (issue) begin
            state_q <= ST_GRANT;
            win_q   <= pick;
            gnt_q   <= onehot(pick);
            scl_q   <= i_scl_req[pick];
            sda_q   <= i_sda_req[pick];
          end
        end
        ST_GRANT: begin
          // A START while our own lines are released came from another master.
          if (start && !(scl_q && sda_q)) begin
            state_q <= ST_HOLD;
            tcnt_q  <= '0;
            scl_q   <= i_scl_req[win_q];
            sda_q   <= i_sda_req[win_q];
          end else if (start || !i_req[win_q]) begin
            state_q <= ST_RELEASE;
            gnt_q   <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
          end else begin
            scl_q <= i_scl_req[win_q];
            sda_q <= i_sda_req[win_q];
          end
        end
        ST_HOLD: begin
          scl_q  <= i_scl_req[win_q];
          sda_q  <= i_sda_req[win_q];
          tcnt_q <= scl_edge ? '0 : tcnt_q + TW'(1);
          if (!scl_edge && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_RELEASE;
            gnt_q     <= '0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
          end else if (stop) begin
            if (win_lock) begin
              state_q <= ST_GRANT;
            end else begin
              state_q <= ST_RELEASE;
              gnt_q   <= '0;
              scl_q   <= 1'b1;
              sda_q   <= 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          ptr_q   <= wrap_inc(win_q);
          gnt_q   <= '0;
          scl_q   <= 1'b1;
          sda_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt     = gnt_q;
  assign o_scl     = scl_q;
  assign o_sda     = sda_q;
  assign o_busy    = busy;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_i2c_mst_arbiter.sv
// Directed and randomized bench for i2c_mst_arbiter with a wired-AND bus model
// and a round-robin grant model.
module tb_i2c_mst_arbiter;

  localparam int N    = 2;
  localparam int IDLE = 16;
  localparam int TO   = 100;
  localparam int H    = 3;
  // Grant after reset: IDLE counting edges plus the grant edge.
  localparam int RESET_GAP = IDLE + 1;
  // Grant after a STOP visible on the wire: detect edge + IDLE counting edges + grant edge.
  localparam int STOP_GAP  = IDLE + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, scl_req, sda_req, gnt;
  logic         ext_scl, ext_sda;
  logic         bus_scl, bus_sda, o_scl, o_sda, busy, timeout;
`ifdef I2C_ARB_LOCK_EN
  logic [N-1:0] lock;
`endif

  int checks    = 0;
  int failures  = 0;
  int to_pulses = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign bus_scl = o_scl & ext_scl;
  assign bus_sda = o_sda & ext_sda;

  always @(posedge clk) begin
    #1;
    if (timeout === 1'b1) to_pulses++;
  end

  i2c_mst_arbiter #(
    .NUM_REQ(N),
    .IDLE_CYCLES(IDLE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_scl_req(scl_req),
    .i_sda_req(sda_req),
`ifdef I2C_ARB_LOCK_EN
    .i_lock   (lock),
`endif
    .i_scl    (bus_scl),
    .i_sda    (bus_sda),
    .o_gnt    (gnt),
    .o_scl    (o_scl),
    .o_sda    (o_sda),
    .o_busy   (busy),
    .o_timeout(timeout)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int r, input logic s, input logic d);
    scl_req[r] = s;
    sda_req[r] = d;
    cyc(H);
  endtask

  task automatic send_start(input int r);
    drive(r, 1'b1, 1'b1);
    drive(r, 1'b1, 1'b0);
    drive(r, 1'b0, 1'b0);
  endtask

  task automatic send_rstart(input int r);
    drive(r, 1'b0, 1'b1);
    drive(r, 1'b1, 1'b1);
    drive(r, 1'b1, 1'b0);
    drive(r, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input int r, input logic [7:0] b);
    logic [8:0] v;
    v = {b, 1'b1};
    for (int i = 8; i >= 0; i--) begin
      drive(r, 1'b0, v[i]);
      drive(r, 1'b1, v[i]);
      drive(r, 1'b0, v[i]);
    end
  endtask

  // Returns at the first sample where the STOP is visible on the wire.
  task automatic send_stop(input int r);
    drive(r, 1'b0, 1'b0);
    drive(r, 1'b1, 1'b0);
    sda_req[r] = 1'b1;
    cyc(1);
  endtask

  task automatic xfer(input int r, input int nbytes, input bit rs);
    send_start(r);
    for (int i = 0; i < nbytes; i++) send_byte(r, 8'($urandom_range(0, 255)));
    if (rs) begin
      send_rstart(r);
      send_byte(r, 8'($urandom_range(0, 255)));
    end
    send_stop(r);
  endtask

  task automatic wait_gnt(input int budget, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (gnt === '0 && n < budget);
  endtask

  task automatic apply_reset(input logic [N-1:0] req_at_release);
    rst     = 1'b1;
    req     = '0;
    scl_req = '1;
    sda_req = '1;
    ext_scl = 1'b1;
    ext_sda = 1'b1;
`ifdef I2C_ARB_LOCK_EN
    lock    = '0;
`endif
    cyc(3);
    req = req_at_release;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst     = 1'b1;
    req     = '0;
    scl_req = '1;
    sda_req = '1;
    ext_scl = 1'b1;
    ext_sda = 1'b1;
`ifdef I2C_ARB_LOCK_EN
    lock    = '0;
`endif
    cyc(2);
    checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (o_scl !== 1'b1) begin failures++; $display("FAIL reset_scl: got %b want 1", o_scl); end
    checks++; if (o_sda !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b want 1", o_sda); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_single();
    int n;
    apply_reset(2'b01);
    wait_gnt(40, n);
    checks++;
    if (gnt !== 2'b01 || n != RESET_GAP) begin
      failures++; $display("FAIL single_grant: gnt=%b after %0d cycles, want 01 after %0d", gnt, n, RESET_GAP);
    end
    send_start(0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_start: busy=%b want 1", busy); end
    send_byte(0, 8'($urandom_range(0, 255)));
    send_byte(0, 8'($urandom_range(0, 255)));
    checks++;
    if (busy !== 1'b1 || gnt !== 2'b01) begin
      failures++; $display("FAIL single_hold: busy=%b gnt=%b want 1/01", busy, gnt);
    end
    send_stop(0);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt_at_stop: gnt=%b want 01", gnt); end
    cyc(1);
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL single_release: gnt=%b busy=%b want 00/0", gnt, busy);
    end
    req = '0;
    cyc(2);
  endtask

  task automatic test_contention();
    int n;
    apply_reset(2'b11);
    wait_gnt(40, n);
    checks++;
    if (gnt !== 2'b01 || n != RESET_GAP) begin
      failures++; $display("FAIL contention_first: gnt=%b after %0d, want 01 after %0d", gnt, n, RESET_GAP);
    end
    xfer(0, 1, 1'b0);
    req[0] = 1'b0;
    wait_gnt(60, n);
    checks++;
    if (gnt !== 2'b10 || n != STOP_GAP) begin
      failures++; $display("FAIL contention_second: gnt=%b after %0d, want 10 after %0d", gnt, n, STOP_GAP);
    end
    req[0] = 1'b1;
    xfer(1, 1, 1'b0);
    req[1] = 1'b0;
    wait_gnt(60, n);
    checks++;
    if (gnt !== 2'b01 || n != STOP_GAP) begin
      failures++; $display("FAIL contention_third: gnt=%b after %0d, want 01 after %0d", gnt, n, STOP_GAP);
    end
    xfer(0, 1, 1'b0);
    req = '0;
    cyc(3);
  endtask

  task automatic test_rstart();
    int n;
    apply_reset(2'b11);
    wait_gnt(40, n);
    send_start(0);
    send_byte(0, 8'($urandom_range(0, 255)));
    send_rstart(0);
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      failures++; $display("FAIL rstart_hold: gnt=%b busy=%b want 01/1", gnt, busy);
    end
    send_byte(0, 8'($urandom_range(0, 255)));
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rstart_after_byte: gnt=%b want 01", gnt); end
    send_stop(0);
    req[0] = 1'b0;
    wait_gnt(60, n);
    checks++;
    if (gnt !== 2'b10 || n != STOP_GAP) begin
      failures++; $display("FAIL rstart_next: gnt=%b after %0d, want 10 after %0d", gnt, n, STOP_GAP);
    end
    req = '0;
    cyc(3);
  endtask

  task automatic test_timeout();
    int n, p0;
    apply_reset(2'b01);
    wait_gnt(40, n);
    drive(0, 1'b1, 1'b1);
    drive(0, 1'b1, 1'b0);
    scl_req[0] = 1'b0;
    p0 = to_pulses;
    n  = 0;
    while (timeout !== 1'b1 && n < TO + 20) begin
      cyc(1);
      n++;
    end
    checks++;
    if (timeout !== 1'b1 || n < TO || n > TO + 3) begin
      failures++; $display("FAIL timeout_latency: pulse=%b after %0d cycles, want 1 within %0d..%0d", timeout, n, TO, TO + 3);
    end
    checks++;
    if (o_scl !== 1'b1 || o_sda !== 1'b1) begin
      failures++; $display("FAIL timeout_lines: scl=%b sda=%b want 1/1", o_scl, o_sda);
    end
    cyc(1);
    checks++;
    if (timeout !== 1'b0 || gnt !== 2'b00 || to_pulses - p0 != 1) begin
      failures++; $display("FAIL timeout_pulse: timeout=%b gnt=%b pulses=%0d want 0/00/1", timeout, gnt, to_pulses - p0);
    end
    scl_req = '1;
    sda_req = '1;
    req     = '0;
    ext_sda = 1'b0;
    cyc(3);
    ext_sda = 1'b1;
    cyc(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_bus_cleanup: busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset(2'b01);
    wait_gnt(40, n);
    send_start(0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 2'b00 || o_scl !== 1'b1 || o_sda !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL async_reset_outputs: gnt=%b scl=%b sda=%b busy=%b want 00/1/1/0", gnt, o_scl, o_sda, busy);
    end
    cyc(2);
    scl_req = '1;
    sda_req = '1;
    req     = 2'b11;
    rst     = 1'b0;
    wait_gnt(40, n);
    checks++;
    if (gnt !== 2'b01 || n != RESET_GAP) begin
      failures++; $display("FAIL async_reset_regrant: gnt=%b after %0d, want 01 after %0d", gnt, n, RESET_GAP);
    end
    req = '0;
    cyc(3);
  endtask

  task automatic test_ext_start();
    int n, p0;
    apply_reset(2'b01);
    wait_gnt(40, n);
    p0 = to_pulses;
    ext_sda = 1'b0;
    cyc(2);
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b1) begin
      failures++; $display("FAIL ext_start_lost: gnt=%b busy=%b want 00/1", gnt, busy);
    end
    cyc(30);
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL ext_start_no_regrant: gnt=%b want 00", gnt); end
    ext_sda = 1'b1;
    wait_gnt(60, n);
    checks++;
    if (gnt !== 2'b01 || n != STOP_GAP) begin
      failures++; $display("FAIL ext_stop_regrant: gnt=%b after %0d, want 01 after %0d", gnt, n, STOP_GAP);
    end
    checks++;
    if (to_pulses != p0) begin
      failures++; $display("FAIL ext_start_no_timeout: pulses=%0d want 0", to_pulses - p0);
    end
    req = '0;
    cyc(3);
  endtask

`ifdef I2C_ARB_LOCK_EN
  task automatic test_lock();
    int n, bad;
    apply_reset(2'b11);
    lock = 2'b01;
    wait_gnt(40, n);
    xfer(0, 1, 1'b0);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1);
      if (gnt !== 2'b01) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL lock_keep: %0d cycles without grant 01, want 0", bad); end
    lock = 2'b00;
    xfer(0, 1, 1'b0);
    req[0] = 1'b0;
    wait_gnt(60, n);
    checks++;
    if (gnt !== 2'b10 || n != STOP_GAP) begin
      failures++; $display("FAIL lock_unlock: gnt=%b after %0d, want 10 after %0d", gnt, n, STOP_GAP);
    end
    req = '0;
    cyc(3);
  endtask
`endif

  task automatic test_random();
    int n, w, ptr, gap;
    logic [N-1:0] pend, want;
    pend = N'($urandom_range(1, 3));
    ptr  = 0;
    gap  = RESET_GAP;
    apply_reset(pend);
    for (int it = 0; it < 8; it++) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
      end
      exp_q.push_back(N'(1) << w);
      wait_gnt(80, n);
      want = exp_q.pop_front();
      checks++;
      if (gnt !== want || n != gap) begin
        failures++; $display("FAIL random_grant[%0d]: gnt=%b after %0d, want %b after %0d", it, gnt, n, want, gap);
      end
      xfer(w, $urandom_range(1, 2), 1'($urandom_range(0, 1)));
      ptr = (w + 1) % N;
      if ($urandom_range(0, 1) == 1) pend[w] = 1'b0;
      pend = pend | N'($urandom_range(0, 3));
      if (pend == '0) pend[$urandom_range(0, N - 1)] = 1'b1;
      req = pend;
      gap = STOP_GAP;
    end
    req = '0;
    cyc(5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rstart();
    test_timeout();
    test_async_reset();
    test_ext_start();
`ifdef I2C_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
